// File: rtl/ex_alu_mdu_pkg.sv
// ex_alu_mdu_pkg: op codes and FSM state encodings shared by the execute-stage integer unit.
package ex_alu_mdu_pkg;
   localparam int OP_W = 5;
   typedef enum logic [OP_W-1:0] {
      OP_ADD   = 5'd0,
      OP_ADDU  = 5'd1,
      OP_SUB   = 5'd2,
      OP_SUBU  = 5'd3,
      OP_SLT   = 5'd4,
      OP_SLTU  = 5'd5,
      OP_AND   = 5'd6,
      OP_OR    = 5'd7,
      OP_XOR   = 5'd8,
      OP_NOR   = 5'd9,
      OP_LUI   = 5'd10,
      OP_SLL   = 5'd11,
      OP_SRL   = 5'd12,
      OP_SRA   = 5'd13,
      OP_MFHI  = 5'd14,
      OP_MFLO  = 5'd15,
      OP_MTHI  = 5'd16,
      OP_MTLO  = 5'd17,
      OP_MULT  = 5'd18,
      OP_MULTU = 5'd19,
      OP_DIV   = 5'd20,
      OP_DIVU  = 5'd21
   } alu_op_e;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } state_e;
endpackage

// File: rtl/ex_div_iter.sv
// ex_div_iter: iterative restoring divider on operand magnitudes with sign fixup; start edge is the setup cycle.
module ex_div_iter #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              signed_op,
   input  logic [DATA_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor,
   input  logic              abort,
   output logic              done,
   output logic [DATA_W-1:0] quotient,
   output logic [DATA_W-1:0] remainder
);
   localparam int CW = $clog2(DATA_W);
   logic              run, neg_a, neg_b, neg_q, neg_r, dz;
   logic [CW-1:0]     step;
   logic [DATA_W-1:0] q, r, d, a_raw;
   logic [DATA_W:0]   r_sh, diff;
   assign neg_a = signed_op & dividend[DATA_W-1];
   assign neg_b = signed_op & divisor[DATA_W-1];
   assign r_sh  = {r, q[DATA_W-1]};
   assign diff  = r_sh - {1'b0, d};
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         run   <= 1'b0;
         done  <= 1'b0;
         step  <= '0;
         q     <= '0;
         r     <= '0;
         d     <= '0;
         a_raw <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         dz    <= 1'b0;
      end else if (abort) begin
         run  <= 1'b0;
         done <= 1'b0;
         step <= '0;
      end else if (start) begin
         run   <= 1'b1;
         done  <= 1'b0;
         step  <= '0;
         q     <= neg_a ? -dividend : dividend;
         d     <= neg_b ? -divisor : divisor;
         r     <= '0;
         a_raw <= dividend;
         neg_q <= neg_a ^ neg_b;
         neg_r <= neg_a;
         dz    <= divisor == '0;
      end else if (run) begin
         q    <= {q[DATA_W-2:0], ~diff[DATA_W]};
         r    <= diff[DATA_W] ? r_sh[DATA_W-1:0] : diff[DATA_W-1:0];
         step <= step + 1'b1;
         if (step == CW'(DATA_W-1)) begin
            run  <= 1'b0;
            done <= 1'b1;
         end
      end
   end
   // divide-by-zero bypasses the iterated result entirely
   assign quotient  = dz ? '1 : neg_q ? -q : q;
   assign remainder = dz ? a_raw : neg_r ? -r : r;
endmodule

// File: rtl/ex_alu_mdu.sv
// ex_alu_mdu: execute-stage ALU with valid/ready handshakes and a serialised multi-cycle mul/div owning HI/LO.
module ex_alu_mdu
   import ex_alu_mdu_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int MUL_LAT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   in_op,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_ov,
   output logic              busy,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
);
   localparam int SHAMT_W = $clog2(DATA_W);
   localparam int CNT_W   = $clog2(MUL_LAT + 1);
   state_e              state, state_d;
   logic [CNT_W-1:0]    cnt;
   logic [DATA_W-1:0]   mul_a, mul_b, div_q, div_r, alu_res;
   logic                mul_s, alu_ov, can_out, accept, is_mul, is_div, mul_fire, div_fire, div_done;
   logic [2*DATA_W-1:0] mul_ea, mul_eb, prod;
   logic [DATA_W:0]     sum, dif;
   logic [SHAMT_W-1:0]  shamt;
   assign can_out  = ~out_valid | out_ready;
   assign in_ready = reset & (state == ST_IDLE) & can_out & ~flush;
   assign accept   = in_valid & in_ready;
   assign is_mul   = (in_op == OP_MULT) || (in_op == OP_MULTU);
   assign is_div   = (in_op == OP_DIV) || (in_op == OP_DIVU);
   assign busy     = state != ST_IDLE;
   assign mul_fire = (state == ST_MUL) && (cnt == CNT_W'(MUL_LAT - 1)) && can_out;
   assign div_fire = (state == ST_DIV) && div_done && can_out;
   assign sum      = {in_a[DATA_W-1], in_a} + {in_b[DATA_W-1], in_b};
   assign dif      = {in_a[DATA_W-1], in_a} - {in_b[DATA_W-1], in_b};
   assign shamt    = in_a[SHAMT_W-1:0];
   // low 2*DATA_W bits of the extended product are exact for both signednesses
   assign mul_ea   = mul_s ? {{DATA_W{mul_a[DATA_W-1]}}, mul_a} : {{DATA_W{1'b0}}, mul_a};
   assign mul_eb   = mul_s ? {{DATA_W{mul_b[DATA_W-1]}}, mul_b} : {{DATA_W{1'b0}}, mul_b};
   assign prod     = mul_ea * mul_eb;
   always_comb begin
      alu_res = '0;
      alu_ov  = 1'b0;
      case (in_op)
         OP_ADD:  begin
            alu_res = sum[DATA_W-1:0];
            alu_ov  = sum[DATA_W] ^ sum[DATA_W-1];
         end
         OP_ADDU: alu_res = sum[DATA_W-1:0];
         OP_SUB:  begin
            alu_res = dif[DATA_W-1:0];
            alu_ov  = dif[DATA_W] ^ dif[DATA_W-1];
         end
         OP_SUBU: alu_res = dif[DATA_W-1:0];
         OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, $signed(in_a) < $signed(in_b)};
         OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, in_a < in_b};
         OP_AND:  alu_res = in_a & in_b;
         OP_OR:   alu_res = in_a | in_b;
         OP_XOR:  alu_res = in_a ^ in_b;
         OP_NOR:  alu_res = ~(in_a | in_b);
         OP_LUI:  alu_res = in_b << (DATA_W / 2);
         OP_SLL:  alu_res = in_b << shamt;
         OP_SRL:  alu_res = in_b >> shamt;
         OP_SRA:  alu_res = $signed(in_b) >>> shamt;
         OP_MFHI: alu_res = hi;
         OP_MFLO: alu_res = lo;
         OP_MTHI: alu_res = in_a;
         OP_MTLO: alu_res = in_a;
         default: ;
      endcase
   end
   always_comb begin
      state_d = state;
      if (flush) state_d = ST_IDLE;
      else if (accept && is_mul) state_d = ST_MUL;
      else if (accept && is_div) state_d = ST_DIV;
      else if (mul_fire || div_fire) state_d = ST_IDLE;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else state <= state_d;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ov    <= 1'b0;
         hi        <= '0;
         lo        <= '0;
         cnt       <= '0;
         mul_a     <= '0;
         mul_b     <= '0;
         mul_s     <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
         cnt       <= '0;
      end else if (accept) begin
         cnt       <= '0;
         out_valid <= ~(is_mul | is_div);
         out_data  <= alu_res;
         out_ov    <= alu_ov;
         if (in_op == OP_MTHI) hi <= in_a;
         if (in_op == OP_MTLO) lo <= in_a;
         if (is_mul) begin
            mul_a <= in_a;
            mul_b <= in_b;
            mul_s <= in_op == OP_MULT;
         end
      end else if (mul_fire || div_fire) begin
         {hi, lo}  <= mul_fire ? prod : {div_r, div_q};
         out_valid <= 1'b1;
         out_data  <= mul_fire ? prod[DATA_W-1:0] : div_q;
         out_ov    <= 1'b0;
      end else begin
         if (out_ready) out_valid <= 1'b0;
         if (state == ST_MUL && cnt != CNT_W'(MUL_LAT - 1)) cnt <= cnt + 1'b1;
      end
   end
   ex_div_iter #(.DATA_W(DATA_W)) u_div (
      .clk       (clk),
      .reset     (reset),
      .start     (accept && is_div),
      .signed_op (in_op == OP_DIV),
      .dividend  (in_a),
      .divisor   (in_b),
      .abort     (flush),
      .done      (div_done),
      .quotient  (div_q),
      .remainder (div_r)
   );
endmodule

// File: tb/tb_ex_alu_mdu.sv
// tb_ex_alu_mdu: directed and random stimulus for ex_alu_mdu against an arithmetic reference model.
module tb_ex_alu_mdu;
   import ex_alu_mdu_pkg::*;
   localparam int DW = 32;
   localparam int MUL_LAT = 4;
   logic clk = 1'b0, reset = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
   logic [4:0] in_op = '0;
   logic [DW-1:0] in_a = '0, in_b = '0;
   logic in_ready, out_valid, out_ov, busy;
   logic [DW-1:0] out_data, hi, lo;
   int errors = 0, checks = 0;
   logic [31:0] m_hi = '0, m_lo = '0;
   logic [31:0] sa_q [10], sb_q [10];
   logic [31:0] held, ra, rb;
   logic [4:0] rop;
   logic stall;
   int sent, recv;
   always #5 clk = ~clk;
   ex_alu_mdu #(.DATA_W(DW), .MUL_LAT(MUL_LAT)) dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_ov(out_ov), .busy(busy), .hi(hi), .lo(lo)
   );
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] d, output logic ov);
      longint sa, sb, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      d = '0;
      ov = 1'b0;
      case (op)
         OP_ADD:  begin r = sa + sb; d = 32'(r); ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
         OP_ADDU: d = a + b;
         OP_SUB:  begin r = sa - sb; d = 32'(r); ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
         OP_SUBU: d = a - b;
         OP_SLT:  d = (sa < sb) ? 32'd1 : 32'd0;
         OP_SLTU: d = (a < b) ? 32'd1 : 32'd0;
         OP_AND:  d = a & b;
         OP_OR:   d = a | b;
         OP_XOR:  d = a ^ b;
         OP_NOR:  d = ~(a | b);
         OP_LUI:  d = b << 16;
         OP_SLL:  d = b << a[4:0];
         OP_SRL:  d = b >> a[4:0];
         OP_SRA:  d = 32'(sb >>> a[4:0]);
         OP_MFHI: d = m_hi;
         OP_MFLO: d = m_lo;
         OP_MTHI: begin m_hi = a; d = a; end
         OP_MTLO: begin m_lo = a; d = a; end
         OP_MULT: begin p = 64'(sa * sb); {m_hi, m_lo} = p; d = m_lo; end
         OP_MULTU: begin p = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = p; d = m_lo; end
         OP_DIV:  begin
            if (b == 0) begin m_lo = '1; m_hi = a; end
            else begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
            d = m_lo;
         end
         OP_DIVU: begin
            if (b == 0) begin m_lo = '1; m_hi = a; end
            else begin m_lo = a / b; m_hi = a % b; end
            d = m_lo;
         end
         default: ;
      endcase
   endtask
   task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      int n = 0;
      in_valid = 1'b1;
      in_op = op;
      in_a = a;
      in_b = b;
      #1;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("issue timeout", {63'b0, in_ready}, 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask
   task automatic wait_out(output int cyc, output logic leak);
      cyc = 0;
      leak = 1'b0;
      while (!out_valid && cyc < 200) begin
         if (in_ready) leak = 1'b1;
         @(negedge clk);
         cyc++;
      end
      if (!out_valid) chk("result timeout", {63'b0, out_valid}, 64'd1);
   endtask
   task automatic run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
      logic [31:0] ed;
      logic eov, leak;
      int cyc, lat;
      model(op, a, b, ed, eov);
      lat = (op == OP_MULT || op == OP_MULTU) ? MUL_LAT : (op == OP_DIV || op == OP_DIVU) ? DW + 1 : 0;
      issue(op, a, b);
      wait_out(cyc, leak);
      chk({tag, " latency"}, 64'(cyc), 64'(lat));
      chk({tag, " data"}, {32'b0, out_data}, {32'b0, ed});
      chk({tag, " ov"}, {63'b0, out_ov}, {63'b0, eov});
      chk({tag, " hi"}, {32'b0, hi}, {32'b0, m_hi});
      chk({tag, " lo"}, {32'b0, lo}, {32'b0, m_lo});
      if (lat != 0) chk({tag, " in_ready low while busy"}, {63'b0, leak}, 64'd0);
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      repeat (3) @(negedge clk);
      chk("reset in_ready", {63'b0, in_ready}, 64'd0);
      chk("reset out_valid", {63'b0, out_valid}, 64'd0);
      chk("reset busy", {63'b0, busy}, 64'd0);
      chk("reset hi/lo", {hi, lo}, 64'd0);
      chk("reset out_data", {32'b0, out_data}, 64'd0);
      reset = 1'b1;
      @(negedge clk);
      run(OP_ADD, 32'h7FFFFFFF, 32'h1, "add ovf");
      chk("add ovf literal", {31'b0, out_ov, out_data}, {31'b0, 1'b1, 32'h80000000});
      run(OP_ADDU, 32'h7FFFFFFF, 32'h1, "addu");
      chk("addu ov literal", {63'b0, out_ov}, 64'd0);
      run(OP_SUB, 32'h80000000, 32'h1, "sub ovf");
      run(OP_SRA, 32'd4, 32'h80000010, "sra");
      chk("sra literal", {32'b0, out_data}, 64'hF8000001);
      run(OP_SRL, 32'd4, 32'h80000010, "srl");
      chk("srl literal", {32'b0, out_data}, 64'h08000001);
      run(OP_SLT, 32'hFFFFFFFF, 32'd1, "slt");
      run(OP_SLTU, 32'hFFFFFFFF, 32'd1, "sltu");
      run(OP_LUI, 32'd0, 32'h0000ABCD, "lui");
      run(OP_MULT, 32'hFFFFFFFE, 32'd3, "mult");
      chk("mult literal", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
      run(OP_MFHI, 32'd0, 32'd0, "mfhi");
      chk("mfhi literal", {32'b0, out_data}, 64'hFFFFFFFF);
      run(OP_DIV, 32'hFFFFFFF9, 32'd2, "div");
      chk("div literal", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
      run(OP_DIVU, 32'd5, 32'd0, "divu by zero");
      chk("divu0 literal", {hi, lo}, 64'h00000005_FFFFFFFF);
      run(OP_DIV, 32'h80000000, 32'hFFFFFFFF, "div most-negative");
      run(OP_MTHI, 32'h1234, 32'd0, "mthi");
      run(OP_MTLO, 32'h5678, 32'd0, "mtlo");
      run(5'd27, 32'h1, 32'h2, "undefined op");
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         sa_q[i] = $urandom;
         sb_q[i] = $urandom;
      end
      sent = 0;
      recv = 0;
      stall = 1'b0;
      held = '0;
      for (int c = 0; c < 100 && recv < 10; c++) begin
         @(negedge clk);
         if (stall) begin
            chk("stall hold valid", {63'b0, out_valid}, 64'd1);
            chk("stall hold data", {32'b0, out_data}, {32'b0, held});
         end
         out_ready = (c % 2) == 0;
         in_valid = sent < 10;
         in_op = OP_ADDU;
         in_a = sa_q[sent < 10 ? sent : 0];
         in_b = sb_q[sent < 10 ? sent : 0];
         #1;
         if (out_valid && out_ready) begin
            chk("stream data", {32'b0, out_data}, {32'b0, 32'(sa_q[recv] + sb_q[recv])});
            recv++;
         end
         stall = out_valid && !out_ready;
         held = out_data;
         if (in_valid && in_ready) sent++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("stream count", 64'(recv), 64'd10);
      @(negedge clk);
      chk("stream no duplicate", {63'b0, out_valid}, 64'd0);
      out_ready = 1'b0;
      issue(OP_ADDU, 32'd1, 32'd2);
      @(negedge clk);
      chk("held before flush", {63'b0, out_valid}, 64'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      out_ready = 1'b1;
      chk("flush drops held result", {63'b0, out_valid}, 64'd0);
      issue(OP_DIV, 32'd100, 32'd7);
      repeat (8) @(negedge clk);
      chk("div busy before flush", {63'b0, busy}, 64'd1);
      flush = 1'b1;
      in_valid = 1'b1;
      in_op = OP_MTHI;
      in_a = 32'hDEAD;
      @(negedge clk);
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush busy", {63'b0, busy}, 64'd0);
      chk("flush out_valid", {63'b0, out_valid}, 64'd0);
      chk("flush hi/lo kept", {hi, lo}, {m_hi, m_lo});
      run(OP_DIV, 32'hFFFFFF9C, 32'd7, "div after flush");
      run(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu");
      issue(OP_MULT, 32'd5, 32'd6);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("async reset out_valid", {63'b0, out_valid}, 64'd0);
      chk("async reset busy", {63'b0, busy}, 64'd0);
      chk("async reset hi/lo", {hi, lo}, 64'd0);
      chk("async reset out_data", {31'b0, out_ov, out_data}, 64'd0);
      chk("async reset in_ready", {63'b0, in_ready}, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      m_hi = '0;
      m_lo = '0;
      run(OP_MFLO, 32'd0, 32'd0, "mflo after reset");
      for (int i = 0; i < 50; i++) begin
         rop = 5'($urandom_range(0, 23));
         if (rop >= 5'd22) rop = 5'($urandom_range(22, 31));
         ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         run(rop, ra, rb, "random");
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
